// File: rtl/vector_line_rasterizer.sv
// vector_line_rasterizer: Bresenham line rasterizer, one pixel per clock into the frame buffer write port.
module vector_line_rasterizer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] x0,
  input  logic [9:0]  y0,
  input  logic [10:0] x1,
  input  logic [9:0]  y1,
  input  logic [3:0]  cmd_color,
  input  logic        frame_end,
  output logic [18:0] w_addr,
  output logic        en_w,
  output logic [3:0]  color_in,
  output logic        done,
  output logic        busy
);
  typedef enum logic {IDLE, DRAW} state_t;
  localparam logic signed [12:0] HS = 13'(H_RES);
  localparam logic signed [12:0] VS = 13'(V_RES);
  localparam logic [18:0] HR = 19'(H_RES);
  state_t state;
  logic pending;
  logic [3:0] color_r;
  logic signed [12:0] cx, cy, ex, ey, dx, dy, err, stx, sty;
  logic signed [12:0] ax0, ay0, ax1, ay1, ddx, ddy, e2;
  logic step_x, step_y, in_rng, last, accept;
  logic [18:0] addr;
  assign ax0 = {{2{x0[10]}}, x0};
  assign ax1 = {{2{x1[10]}}, x1};
  assign ay0 = {{3{y0[9]}}, y0};
  assign ay1 = {{3{y1[9]}}, y1};
  assign ddx = ax1 - ax0;
  assign ddy = ay1 - ay0;
  assign e2 = err <<< 1;
  assign step_x = e2 > -dy;
  assign step_y = e2 < dx;
  assign in_rng = !cx[12] && cx < HS && !cy[12] && cy < VS;
  // Only meaningful when in_rng, so the coordinates are non-negative here
  assign addr = 19'(cy) * HR + 19'(cx);
  assign last = cx == ex && cy == ey;
  assign cmd_ready = state == IDLE && !pending;
  assign accept = cmd_valid && cmd_ready;
  assign busy = state == DRAW || pending || en_w;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= 1'b0;
      done <= 1'b0;
      en_w <= 1'b0;
      w_addr <= '0;
      color_in <= '0;
      color_r <= '0;
      cx <= '0;
      cy <= '0;
      ex <= '0;
      ey <= '0;
      dx <= '0;
      dy <= '0;
      err <= '0;
      stx <= '0;
      sty <= '0;
    end else begin
      en_w <= 1'b0;
      // An IDLE state guarantees the next cycle carries no pixel, so done trails the last en_w
      done <= pending && !done && state == IDLE;
      pending <= done ? 1'b0 : (pending || frame_end);
      if (state == IDLE) begin
        if (accept) begin
          state <= DRAW;
          cx <= ax0;
          cy <= ay0;
          ex <= ax1;
          ey <= ay1;
          color_r <= cmd_color;
          dx <= ddx[12] ? -ddx : ddx;
          dy <= ddy[12] ? -ddy : ddy;
          err <= (ddx[12] ? -ddx : ddx) - (ddy[12] ? -ddy : ddy);
          stx <= ddx[12] ? -13'sd1 : 13'sd1;
          sty <= ddy[12] ? -13'sd1 : 13'sd1;
        end
      end else begin
        en_w <= in_rng;
        if (in_rng) begin
          w_addr <= addr;
          color_in <= color_r;
        end
        if (last) state <= IDLE;
        else begin
          cx <= step_x ? cx + stx : cx;
          cy <= step_y ? cy + sty : cy;
          err <= err - (step_x ? dy : 13'sd0) + (step_y ? dx : 13'sd0);
        end
      end
    end
  end
endmodule

// File: tb/tb_vector_line_rasterizer.sv
// tb_vector_line_rasterizer: directed and random line commands checked against an integer Bresenham model.
module tb_vector_line_rasterizer;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, frame_end = 1'b0;
  logic [10:0] x0 = '0, x1 = '0;
  logic [9:0] y0 = '0, y1 = '0;
  logic [3:0] cmd_color = '0;
  logic cmd_ready, en_w, done, busy;
  logic [18:0] w_addr;
  logic [3:0] color_in;
  int checks = 0, errors = 0, exp_addr = 0;

  vector_line_rasterizer #(.H_RES(640), .V_RES(480)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .cmd_color(cmd_color), .frame_end(frame_end),
    .w_addr(w_addr), .en_w(en_w), .color_in(color_in), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fe: -1 none, -2 with the command, otherwise pixel index during which frame_end pulses
  task automatic line(input int ax0, input int ay0, input int ax1, input int ay1, input int col, input int fe);
    int px[$], py[$];
    int x, y, dx, dy, sx, sy, err, e2, n;
    bit inr;
    x = ax0; y = ay0;
    dx = ax1 > ax0 ? ax1 - ax0 : ax0 - ax1;
    dy = ay1 > ay0 ? ay1 - ay0 : ay0 - ay1;
    sx = ax1 < ax0 ? -1 : 1;
    sy = ay1 < ay0 ? -1 : 1;
    err = dx - dy;
    forever begin
      px.push_back(x); py.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx) begin err += dx; y += sy; end
    end
    n = px.size();
    chk("ready_before_cmd", cmd_ready, 1);
    x0 = ax0[10:0]; y0 = ay0[9:0]; x1 = ax1[10:0]; y1 = ay1[9:0];
    cmd_color = col[3:0];
    cmd_valid = 1'b1;
    frame_end = fe == -2;
    tick();
    cmd_valid = 1'b0;
    frame_end = 1'b0;
    chk("busy_first_draw", busy, 1);
    chk("no_en_w_at_n1", en_w, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      inr = px[i] >= 0 && px[i] < 640 && py[i] >= 0 && py[i] < 480;
      if (inr) exp_addr = py[i] * 640 + px[i];
      chk("en_w", en_w, 32'(inr));
      chk("w_addr", w_addr, exp_addr);
      if (inr) chk("color_in", color_in, col);
      chk("cmd_ready_during", cmd_ready, (i == n - 1 && fe == -1) ? 1 : 0);
      chk("done_during", done, 0);
      if (i == fe) frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
    end
    chk("en_w_after", en_w, 0);
    if (fe != -1) begin
      chk("done_pulse", done, 1);
      chk("ready_in_done", cmd_ready, 0);
      tick();
      chk("done_single", done, 0);
      chk("ready_after_done", cmd_ready, 1);
      chk("busy_after_done", busy, 0);
    end else begin
      chk("done_idle", done, 0);
      chk("busy_idle", busy, 0);
    end
  endtask

  initial begin
    int a, b;
    tick();
    tick();
    chk("rst_en_w", en_w, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_color", color_in, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1);
    line(0, 0, 3, 0, 5, -1);
    line(5, 2, 2, 2, 6, -1);
    line(10, 10, 12, 15, 7, -1);
    line(-2, 0, 1, 0, 8, -1);
    line(100, 500, 110, 500, 2, -1);
    line(7, 7, 7, 7, 11, -1);
    line(639, 479, 642, 481, 12, -1);
    line(0, 1, 3, 1, 9, 1);
    line(4, 4, 6, 4, 3, -2);
    for (int k = 0; k < 25; k++) begin
      a = int'($urandom_range(0, 680)) - 20;
      b = int'($urandom_range(0, 510)) - 20;
      line(a, b, a + int'($urandom_range(0, 30)) - 15, b + int'($urandom_range(0, 30)) - 15,
           int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? -2 : -1);
    end
    x0 = 11'd0; y0 = 10'd5; x1 = 11'd20; y1 = 10'd5; cmd_color = 4'd1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_en_w", en_w, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_en_w", en_w, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_en_w", en_w, 0);
      chk("post_reset_ready", cmd_ready, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_line_rasterizer.md
Name: vector_line_rasterizer

Overview:
- Upstream stage of the triple-buffered frame buffer controller. Accepts line-segment commands from the vector generator and rasterizes them with integer Bresenham, producing one pixel per clock.
- Drives the controller's write port: pixel address, write enable and colour.
- Generates the end-of-frame "done" pulse only once every pixel of the frame has been issued, so buffer rotation never cuts a line in half.

Parameters:
- H_RES, 640, visible columns; used for clipping and as the address row stride.
- V_RES, 480, visible rows; used for clipping.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  line command present.
- cmd_ready  out  1  block can accept a command.
- x0  in  11  start x, signed two's complement.
- y0  in  10  start y, signed.
- x1  in  11  end x, signed.
- y1  in  10  end y, signed.
- cmd_color  in  4  colour for the segment.
- frame_end  in  1  one-cycle request: the frame's command list is complete.
- w_addr  out  19  pixel address, y*H_RES + x.
- en_w  out  1  write strobe for w_addr/color_in.
- color_in  out  4  pixel colour (named for the consumer port).
- done  out  1  one-cycle end-of-frame pulse to the controller.
- busy  out  1  high while drawing or while a frame end is pending.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; w_addr=0; en_w=0; color_in=0; done=0; busy=0; frame-end pending flag cleared. Reset mid-line abandons the line with no further en_w.
- Command acceptance:
  - cmd_ready = (state==IDLE) && !pending.
  - A command is accepted in cycle N when cmd_valid && cmd_ready.
  - On acceptance the block latches x0, y0, x1, y1 and colour, then computes dx=|x1-x0|, dy=|y1-y0|, sx=sign(x1-x0), sy=sign(y1-y0), err=dx-dy.
  - err is 13-bit signed; all Bresenham arithmetic is sign-extended to 13 bits.
- States:
  - IDLE -> DRAW on accept.
  - DRAW: each cycle, emit the current point (cx,cy). If cx==x1 && cy==y1, return to IDLE. Otherwise step: e2=2*err; if e2>-dy then err-=dy, cx+=sx; if e2<dx then err+=dx, cy+=sy (both updates may apply in the same cycle).
- Output pipeline:
  - Emitted points are registered. The first en_w appears in cycle N+2.
  - The block produces max(dx,dy)+1 consecutive DRAW cycles with no gaps.
  - w_addr = cy*H_RES + cx, computed in 19 bits unsigned from in-range coordinates.
- Clipping: a point with cx<0, cx>=H_RES, cy<0 or cy>=V_RES still takes its DRAW cycle, but en_w=0 and w_addr holds its previous value. Off-screen segments are consumed silently.
- Degenerate segment: x0==x1 && y0==y1 gives exactly one DRAW cycle and one pixel.
- Back-to-back commands: cmd_ready rises the cycle after the last DRAW cycle, so there is at least one idle cycle between segments.
- Frame end:
  - frame_end sets pending, whatever the state; a repeat while pending is absorbed.
  - done pulses high for exactly one cycle once pending is set, state is IDLE and the output pipeline holds no en_w. pending clears in that same cycle.
  - done therefore falls at least one cycle after the last en_w of the frame.
  - frame_end arriving in the same cycle as a command acceptance: the command is accepted first and done follows that line.
- busy = (state==DRAW) || pending || en_w.

Test Plan:
- Horizontal line: (0,0)->(3,0), colour 5, accepted at N -> en_w high for cycles N+2..N+5; w_addr 0,1,2,3; color_in=5; cmd_ready back high at N+5.
- Reverse horizontal line: (5,2)->(2,2) -> w_addr 1285,1284,1283,1282; 4 en_w pulses.
- Steep line: (10,10)->(12,15) -> 6 contiguous en_w pulses; first w_addr 6410, last 9612; y increments by exactly 1 on every pulse.
- Clipping: (-2,0)->(1,0) -> 4 DRAW cycles, en_w only on the last two (w_addr 0,1). A segment fully at y=500 -> no en_w, cmd_ready returns.
- Frame end mid-line: frame_end pulsed during the 2nd pixel of a 4-pixel line -> cmd_ready low; done is a single-cycle pulse exactly one cycle after the final en_w. cmd_ready rises the cycle after done.
- Reset mid-line: rst_n=0 asynchronously during DRAW -> en_w, done and busy drop immediately. After release, cmd_ready=1 and no residual pixels are emitted.
